// File: rtl/display_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : display_pkg
// Description : Shared types and constants for the 4-digit 7-segment scan
//               controller: FSM state encoding, active-low hex glyph table,
//               blank-display constants and an anode-select helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SCAN  = 2'd2
   } state_t;

   localparam logic [7:0] ANODO_OFF = 8'hFF;
   localparam logic [6:0] SEG_OFF   = 7'h7F;

   // Active-low segment patterns, bit order gfedcba, indexed by nibble value.
   localparam logic [6:0] c_glyph_table [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   // Active-low enable for one of the four digits; upper four anodes stay off.
   function automatic logic [7:0] anode_for(input logic [1:0] idx);
      return {4'hF, ~(4'b0001 << idx)};
   endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : hex_to_seg
// Description : Combinational hex nibble to active-low 7-segment glyph.
// Ports       : i_nibble [3:0] - value to render
//               o_seg    [6:0] - active-low segments, gfedcba
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module hex_to_seg
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = c_glyph_table[i_nibble];

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : display_scan_controller
// Description : Accepts a 16-bit value through a valid/ready handshake and
//               time-multiplexes its four hex nibbles onto a common-anode
//               7-segment display, holding each digit REFRESH_DIV cycles.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zero
//               digits (digit 0 is always shown).
// Parameters  : REFRESH_DIV   - clk cycles per digit (1..2^20)
// Ports       : clk           - system clock, rising edge
//               rst           - asynchronous active-high reset
//               dato          - value to display, nibble i -> digit i
//               dato_valido   - producer offers dato
//               dato_listo    - controller accepts dato this cycle
//               limpiar       - synchronous blank / return to idle
//               anodo         - active-low digit enables (7:4 always 1)
//               segmentos     - active-low segments, gfedcba
//               digito_actual - index of the digit being driven
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module display_scan_controller
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dato,
   input  logic        dato_valido,
   output logic        dato_listo,
   input  logic        limpiar,
   output logic [7:0]  anodo,
   output logic [6:0]  segmentos,
   output logic [2:0]  digito_actual
);

   localparam logic [19:0] c_PRESC_LAST = 20'(REFRESH_DIV - 1);

   state_t      r_state;
   logic [15:0] r_dato;
   logic [19:0] r_presc;
   logic [1:0]  r_digit;
   logic [7:0]  r_anodo;
   logic [6:0]  r_seg;
   logic        r_listo;

   logic        w_tc;
   logic [1:0]  w_next_digit;
   logic [3:0]  w_nibble;
   logic [6:0]  w_glyph;
   logic        w_blank;
   logic [7:0]  w_show_anodo;
   logic [6:0]  w_show_seg;

   assign w_tc = (r_presc == c_PRESC_LAST);

   // Outputs are registered, so the glyph is looked up for the digit that
   // will be active after the coming edge. Leaving LATCH always targets 0.
   always_comb begin
      w_next_digit = 2'd0;
      if (r_state == ST_SCAN) begin
         w_next_digit = w_tc ? (r_digit + 2'd1) : r_digit;
      end
   end

   assign w_nibble = r_dato[{w_next_digit, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .i_nibble (w_nibble),
      .o_seg    (w_glyph)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every higher nibble are zero.
   always_comb begin
      w_blank = 1'b0;
      case (w_next_digit)
         2'd1:    w_blank = (r_dato[15:4]  == 12'h000);
         2'd2:    w_blank = (r_dato[15:8]  == 8'h00);
         2'd3:    w_blank = (r_dato[15:12] == 4'h0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   assign w_show_anodo = w_blank ? ANODO_OFF : anode_for(w_next_digit);
   assign w_show_seg   = w_blank ? SEG_OFF   : w_glyph;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_dato  <= 16'h0000;
         r_presc <= 20'd0;
         r_digit <= 2'd0;
         r_anodo <= ANODO_OFF;
         r_seg   <= SEG_OFF;
         r_listo <= 1'b1;
      end else if (limpiar) begin
         // Clear wins over a simultaneous transfer; dato is not captured.
         r_state <= ST_IDLE;
         r_presc <= 20'd0;
         r_digit <= 2'd0;
         r_anodo <= ANODO_OFF;
         r_seg   <= SEG_OFF;
         r_listo <= 1'b1;
      end else if (dato_valido && r_listo) begin
         // Transfer from IDLE or SCAN; any scan in progress is abandoned.
         r_state <= ST_LATCH;
         r_dato  <= dato;
         r_presc <= 20'd0;
         r_digit <= 2'd0;
         r_anodo <= ANODO_OFF;
         r_seg   <= SEG_OFF;
         r_listo <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_LATCH: begin
               r_state <= ST_SCAN;
               r_presc <= 20'd0;
               r_digit <= w_next_digit;
               r_anodo <= w_show_anodo;
               r_seg   <= w_show_seg;
               r_listo <= 1'b1;
            end
            ST_SCAN: begin
               r_presc <= w_tc ? 20'd0 : (r_presc + 20'd1);
               r_digit <= w_next_digit;
               r_anodo <= w_show_anodo;
               r_seg   <= w_show_seg;
            end
            default: begin
               r_state <= ST_IDLE;
               r_anodo <= ANODO_OFF;
               r_seg   <= SEG_OFF;
               r_listo <= 1'b1;
            end
         endcase
      end
   end

   assign dato_listo    = r_listo;
   assign anodo         = r_anodo;
   assign segmentos     = r_seg;
   assign digito_actual = {1'b0, r_digit};

endmodule : display_scan_controller
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : tb_display_scan_controller
// Description : Self-checking bench. Two instances (REFRESH_DIV=4 and 1)
//               share stimulus; both are compared every cycle against a
//               behavioural model that derives the shown digit from elapsed
//               scan time. A vector table covers the basic scan sequence,
//               hand sequences cover clear, restart, leading zeros and
//               asynchronous reset, followed by random traffic.
//               Honours LEADING_ZERO_BLANK_EN for expected values.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_display_scan_controller;

   logic        clk;
   logic        rst;
   logic [15:0] dato;
   logic        valido;
   logic        limpiar;

   logic        listo4, listo1;
   logic [7:0]  an4, an1;
   logic [6:0]  sg4, sg1;
   logic [2:0]  dg4, dg1;

   int n_vec = 0;
   int n_err = 0;

   display_scan_controller #(.REFRESH_DIV(4)) u_dut4 (
      .clk           (clk),
      .rst           (rst),
      .dato          (dato),
      .dato_valido   (valido),
      .dato_listo    (listo4),
      .limpiar       (limpiar),
      .anodo         (an4),
      .segmentos     (sg4),
      .digito_actual (dg4)
   );

   display_scan_controller #(.REFRESH_DIV(1)) u_dut1 (
      .clk           (clk),
      .rst           (rst),
      .dato          (dato),
      .dato_valido   (valido),
      .dato_listo    (listo1),
      .limpiar       (limpiar),
      .anodo         (an1),
      .segmentos     (sg1),
      .digito_actual (dg1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 latch, 2 scan; m_t counts cycles spent in scan.
   int          m_mode [2];
   logic [15:0] m_val  [2];
   int          m_t    [2];

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         m_val[k]  = 16'h0000;
         m_t[k]    = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_mode[k] = 0; m_val[k] = 16'h0000; m_t[k] = 0;
         end else if (limpiar) begin
            m_mode[k] = 0; m_t[k] = 0;
         end else if (valido && m_mode[k] != 1) begin
            m_mode[k] = 1; m_val[k] = dato; m_t[k] = 0;
         end else if (m_mode[k] == 1) begin
            m_mode[k] = 2; m_t[k] = 0;
         end else if (m_mode[k] == 2) begin
            m_t[k] = m_t[k] + 1;
         end
      end
   endtask

   task automatic model_expect(input int k, output logic [7:0] an, output logic [6:0] sg,
                               output logic [2:0] dg, output logic ls);
      int   d;
      logic blank;
      an = 8'hFF; sg = 7'h7F; dg = 3'd0;
      ls = (m_mode[k] != 1);
      if (m_mode[k] == 2) begin
         d     = (m_t[k] / div_of(k)) % 4;
         dg    = 3'(d);
         blank = LZB && (d >= 1) && ((m_val[k] >> (4 * d)) == 16'h0000);
         if (!blank) begin
            an = 8'hFF & ~(8'd1 << d);
            sg = glyph(4'(m_val[k] >> (4 * d)));
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] ea; logic [6:0] es; logic [2:0] ed; logic el;
      model_expect(0, ea, es, ed, el);
      chk("div4_anodo", 32'(an4), 32'(ea));
      chk("div4_seg", 32'(sg4), 32'(es));
      chk("div4_digit", 32'(dg4), 32'(ed));
      chk("div4_listo", 32'(listo4), 32'(el));
      model_expect(1, ea, es, ed, el);
      chk("div1_anodo", 32'(an1), 32'(ea));
      chk("div1_seg", 32'(sg1), 32'(es));
      chk("div1_digit", 32'(dg1), 32'(ed));
      chk("div1_listo", 32'(listo1), 32'(el));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] dato;
      logic        valido;
      logic        limpiar;
      logic [7:0]  an;
      logic [6:0]  sg;
      logic        ls;
   } vec_t;

   vec_t tbl [18];

   initial begin
      logic [7:0] an_seq [4];
      logic [6:0] sg_seq [4];
      an_seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      sg_seq = '{7'h0E, 7'h08, 7'h24, 7'h79};   // F, A, 2, 1 of 16'h12AF
      tbl[0] = '{16'h12AF, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0};
      for (int i = 1; i < 18; i++) begin
         tbl[i] = '{16'h0000, 1'b0, 1'b0, an_seq[((i - 1) / 4) % 4], sg_seq[((i - 1) / 4) % 4], 1'b1};
      end

      rst = 1'b1; dato = 16'h0000; valido = 1'b0; limpiar = 1'b0;
      model_reset();
      #1;
      check_all();
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Basic load and scan with REFRESH_DIV=4.
      for (int i = 0; i < 18; i++) begin
         dato = tbl[i].dato; valido = tbl[i].valido; limpiar = tbl[i].limpiar;
         tick();
         chk($sformatf("tbl%0d_anodo", i), 32'(an4), 32'(tbl[i].an));
         chk($sformatf("tbl%0d_seg", i), 32'(sg4), 32'(tbl[i].sg));
         chk($sformatf("tbl%0d_listo", i), 32'(listo4), 32'(tbl[i].ls));
      end

      // Clear and transfer together in SCAN: clear wins.
      dato = 16'h5555; valido = 1'b1; limpiar = 1'b1;
      tick();
      chk("clr_anodo", 32'(an4), 32'h0000_00FF);
      chk("clr_listo", 32'(listo4), 32'd1);
      valido = 1'b0; limpiar = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_hold_anodo", 32'(an4), 32'h0000_00FF);
      end

      // New value mid digit 2 restarts at digit 0 with a full dwell.
      dato = 16'h12AF; valido = 1'b1;
      tick();
      valido = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_digit2", 32'(dg4), 32'd2);
      dato = 16'h0003; valido = 1'b1;
      tick();
      chk("restart_latch_listo", 32'(listo4), 32'd0);
      chk("restart_latch_anodo", 32'(an4), 32'h0000_00FF);
      valido = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("restart_d0_seg", 32'(sg4), 32'h0000_0030);
         chk("restart_d0_anodo", 32'(an4), 32'h0000_00FE);
      end
      tick();
      chk("restart_d1_anodo", 32'(an4), LZB ? 32'h0000_00FF : 32'h0000_00FD);
      chk("restart_d1_seg", 32'(sg4), LZB ? 32'h0000_007F : 32'h0000_0040);

      // Leading zeros with 16'h0005 over one full scan.
      dato = 16'h0005; valido = 1'b1;
      tick();
      valido = 1'b0;
      tick();
      chk("lz_d0_seg", 32'(sg4), 32'h0000_0012);
      for (int i = 0; i < 16; i++) tick();

      // Asynchronous reset between edges during SCAN.
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_anodo", 32'(an4), 32'h0000_00FF);
      chk("async_rst_seg", 32'(sg4), 32'h0000_007F);
      chk("async_rst_listo", 32'(listo4), 32'd1);
      check_all();
      #2 rst = 1'b0;
      tick();

      // REFRESH_DIV=1 advances every cycle.
      dato = 16'h8888; valido = 1'b1;
      tick();
      valido = 1'b0;
      begin
         logic [7:0] seq [4];
         seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
         for (int i = 0; i < 5; i++) begin
            tick();
            chk("div1_seq_anodo", 32'(an1), 32'(seq[i % 4]));
            chk("div1_seq_seg", 32'(sg1), 32'h0000_0000);
         end
      end

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         valido  = ($urandom_range(0, 7) == 0);
         limpiar = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 3))
            0:       dato = 16'($urandom_range(0, 15));
            1:       dato = 16'($urandom_range(0, 255));
            2:       dato = 16'($urandom_range(0, 4095));
            default: dato = 16'($urandom);
         endcase
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_display_scan_controller
`default_nettype wire
